// File: rtl/hdlc_bus_ctrl_if.sv
// Host/HDLC-side signal bundle for hdlc_bus_ctrl.
// master = controller view, slave = HDLC core plus host view.
interface hdlc_bus_ctrl_if;
  logic [2:0] Address;
  logic       WriteEnable;
  logic       ReadEnable;
  logic [7:0] DataIn;
  logic [7:0] DataOut;
  logic       Rx_Ready;
  logic       Tx_Done;
  logic [7:0] TxData;
  logic       TxValid;
  logic       TxLast;
  logic       TxReady;
  logic [7:0] RxData;
  logic       RxValid;
  logic       RxLast;
  logic       RxReady;
  logic       TxOverrun;

  modport master (
    output Address, WriteEnable, ReadEnable, DataIn, TxReady,
           RxData, RxValid, RxLast, TxOverrun,
    input  DataOut, Rx_Ready, Tx_Done, TxData, TxValid, TxLast, RxReady
  );

  modport slave (
    input  Address, WriteEnable, ReadEnable, DataIn, TxReady,
           RxData, RxValid, RxLast, TxOverrun,
    output DataOut, Rx_Ready, Tx_Done, TxData, TxValid, TxLast, RxReady
  );
endinterface

// File: rtl/hdlc_bus_ctrl.sv
// Bridges host byte streams to the HDLC register interface: drains RX frames,
// loads and starts TX frames, round-robin between the two in IDLE.
module hdlc_bus_ctrl (
  input  logic            Clk,
  input  logic            Rst,
  hdlc_bus_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, RX_LEN, RX_LENW, RX_RD, RX_RDW, RX_OUT, TX_WAIT, TX_LOAD, TX_START
  } state_e;

  localparam logic [2:0] A_TX_SC   = 3'd0;
  localparam logic [2:0] A_TX_BUFF = 3'd1;
  localparam logic [2:0] A_RX_SC   = 3'd2;
  localparam logic [2:0] A_RX_BUFF = 3'd3;
  localparam logic [2:0] A_RX_LEN  = 3'd4;
  localparam logic [7:0] CMD_BIT1  = 8'h02;
  localparam logic [6:0] TX_LIMIT_M1 = 7'd125;

  state_e     state_q, state_d;
  logic [2:0] addr_q, addr_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic [7:0] din_q, din_d;
  logic       tx_ready_q, tx_ready_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_last_q, rx_last_d;
  logic       tx_ovr_q, tx_ovr_d;
  logic [6:0] cnt_q, cnt_d;
  logic [6:0] len_q, len_d;
  logic       rx_prio_q, rx_prio_d;
  logic       discard_q, discard_d;
  logic       start_done_q, start_done_d;
  logic       tx_accept;

  assign tx_accept = bus.TxValid & tx_ready_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = 1'b0;
    re_d         = 1'b0;
    din_d        = din_q;
    tx_ready_d   = tx_ready_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_last_d    = rx_last_q;
    tx_ovr_d     = 1'b0;
    cnt_d        = cnt_q;
    len_d        = len_q;
    rx_prio_d    = rx_prio_q;
    discard_d    = discard_q;
    start_done_d = start_done_q;

    case (state_q)
      // A drop/start write still on the bus must land before Rx_Ready is trusted again.
      IDLE: begin
        tx_ready_d = 1'b0;
        if (!we_q && bus.Rx_Ready && (!bus.TxValid || rx_prio_q)) begin
          state_d   = RX_LEN;
          re_d      = 1'b1;
          addr_d    = A_RX_LEN;
          rx_prio_d = 1'b0;
          cnt_d     = 7'd0;
        end else if (!we_q && bus.TxValid) begin
          state_d   = TX_WAIT;
          rx_prio_d = 1'b1;
          cnt_d     = 7'd0;
        end else begin
          state_d = IDLE;
        end
      end
      RX_LEN: state_d = RX_LENW;
      RX_LENW: begin
        len_d = bus.DataOut[7] ? 7'd127 : bus.DataOut[6:0];
        if (bus.DataOut == 8'd0) begin
          we_d    = 1'b1;
          addr_d  = A_RX_SC;
          din_d   = CMD_BIT1;
          state_d = IDLE;
        end else begin
          re_d    = 1'b1;
          addr_d  = A_RX_BUFF;
          state_d = RX_RD;
        end
      end
      RX_RD: state_d = RX_RDW;
      RX_RDW: begin
        rx_data_d  = bus.DataOut;
        rx_valid_d = 1'b1;
        rx_last_d  = ((cnt_q + 7'd1) == len_q);
        cnt_d      = cnt_q + 7'd1;
        state_d    = RX_OUT;
      end
      RX_OUT: begin
        if (bus.RxReady) begin
          rx_valid_d = 1'b0;
          rx_last_d  = 1'b0;
          if (rx_last_q) begin
            state_d = IDLE;
          end else begin
            re_d    = 1'b1;
            addr_d  = A_RX_BUFF;
            state_d = RX_RD;
          end
        end else begin
          state_d = RX_OUT;
        end
      end
      TX_WAIT: begin
        if (bus.Tx_Done) begin
          tx_ready_d = 1'b1;
          state_d    = TX_LOAD;
        end else begin
          state_d = TX_WAIT;
        end
      end
      // The 126th byte without TxLast truncates the frame; the tail is swallowed in TX_START.
      TX_LOAD: begin
        if (tx_accept) begin
          we_d   = 1'b1;
          addr_d = A_TX_BUFF;
          din_d  = bus.TxData;
          cnt_d  = cnt_q + 7'd1;
          if (bus.TxLast) begin
            tx_ready_d   = 1'b0;
            start_done_d = 1'b0;
            state_d      = TX_START;
          end else if (cnt_q == TX_LIMIT_M1) begin
            tx_ovr_d     = 1'b1;
            discard_d    = 1'b1;
            start_done_d = 1'b0;
            state_d      = TX_START;
          end else begin
            state_d = TX_LOAD;
          end
        end else begin
          state_d = TX_LOAD;
        end
      end
      TX_START: begin
        if (!start_done_q) begin
          we_d         = 1'b1;
          addr_d       = A_TX_SC;
          din_d        = CMD_BIT1;
          start_done_d = 1'b1;
        end else begin
          we_d = 1'b0;
        end
        if (discard_q) begin
          if (tx_accept && bus.TxLast) begin
            discard_d  = 1'b0;
            tx_ready_d = 1'b0;
            state_d    = IDLE;
          end else begin
            state_d = TX_START;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= IDLE;
      addr_q       <= 3'd0;
      we_q         <= 1'b0;
      re_q         <= 1'b0;
      din_q        <= 8'd0;
      tx_ready_q   <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_last_q    <= 1'b0;
      tx_ovr_q     <= 1'b0;
      cnt_q        <= 7'd0;
      len_q        <= 7'd0;
      rx_prio_q    <= 1'b1;
      discard_q    <= 1'b0;
      start_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      re_q         <= re_d;
      din_q        <= din_d;
      tx_ready_q   <= tx_ready_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_last_q    <= rx_last_d;
      tx_ovr_q     <= tx_ovr_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      rx_prio_q    <= rx_prio_d;
      discard_q    <= discard_d;
      start_done_q <= start_done_d;
    end
  end

  assign bus.Address     = addr_q;
  assign bus.WriteEnable = we_q;
  assign bus.ReadEnable  = re_q;
  assign bus.DataIn      = din_q;
  assign bus.TxReady     = tx_ready_q;
  assign bus.RxData      = rx_data_q;
  assign bus.RxValid     = rx_valid_q;
  assign bus.RxLast      = rx_last_q;
  assign bus.TxOverrun   = tx_ovr_q;
endmodule

// File: tb/tb_hdlc_bus_ctrl.sv
// Scoreboard bench for hdlc_bus_ctrl: directed frames push expected bus/host
// events; a negedge monitor pops and compares every observed event.
module tb_hdlc_bus_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hdlc_bus_ctrl_if bus();
  hdlc_bus_ctrl dut (.Clk(clk), .Rst(rst), .bus(bus));

  typedef struct { string name; int act; int exp; } chk_t;
  chk_t        chk_q[$];
  logic [15:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int rd_seen = 0;
  int rx_loaded = 0;
  int rx_consumed = 0;
  int rd_idx = 0;
  logic [7:0] rx_len_v = 8'd0;
  logic [7:0] rx_mem [0:7];
  logic [7:0] tx_buf [0:131];

  localparam logic [3:0] K_WR = 4'd1, K_RD = 4'd2, K_RXB = 4'd3, K_OVR = 4'd4;

  function automatic logic [15:0] ev(logic [3:0] k, logic [3:0] a, logic [7:0] d);
    return {k, a, d};
  endfunction

  function automatic int out_vec();
    return int'({7'd0, bus.Address, bus.WriteEnable, bus.ReadEnable, bus.DataIn, bus.TxReady,
                 bus.RxValid, bus.RxLast, bus.RxData, bus.TxOverrun});
  endfunction

  // HDLC core model: frame pending while loaded != consumed
  assign bus.Rx_Ready = (rx_loaded != rx_consumed);

  always @(posedge clk) begin
    if (bus.ReadEnable && bus.Address == 3'd4) begin
      bus.DataOut <= rx_len_v;
      rd_idx      <= 0;
    end else if (bus.ReadEnable && bus.Address == 3'd3) begin
      bus.DataOut <= rx_mem[rd_idx[2:0]];
      rd_idx      <= rd_idx + 1;
      if (rd_idx + 1 == int'(rx_len_v)) rx_consumed <= rx_consumed + 1;
    end
    if (bus.WriteEnable && bus.Address == 3'd2 && bus.DataIn == 8'h02)
      rx_consumed <= rx_consumed + 1;
  end

  task automatic sb_check(string name, logic [15:0] got);
    logic [15:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: got %h, nothing expected", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        bad++;
        $display("FAIL %s: got %h expected %h", name, got, e);
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    chk_t c;
    if (bus.WriteEnable || bus.ReadEnable) begin
      total++;
      if (bus.WriteEnable && bus.ReadEnable) begin
        bad++;
        $display("FAIL strobe exclusive: got WE=1 RE=1 expected one");
      end
    end
    if (bus.WriteEnable) sb_check("bus write", ev(K_WR, {1'b0, bus.Address}, bus.DataIn));
    if (bus.ReadEnable) begin
      rd_seen++;
      sb_check("bus read", ev(K_RD, {1'b0, bus.Address}, 8'h00));
    end
    if (bus.RxValid && bus.RxReady) sb_check("rx byte", ev(K_RXB, {3'b000, bus.RxLast}, bus.RxData));
    if (bus.TxOverrun) sb_check("tx overrun", ev(K_OVR, 4'h0, 8'h00));
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      total++;
      if (c.act != c.exp) begin
        bad++;
        $display("FAIL %s: got %0h expected %0h", c.name, c.act, c.exp);
      end
    end
  end

  task automatic chk(string n, int a, int e);
    chk_q.push_back('{name: n, act: a, exp: e});
  endtask

  task automatic exp_rx();
    exp_q.push_back(ev(K_RD, 4'd4, 8'h00));
    if (rx_len_v == 8'd0) exp_q.push_back(ev(K_WR, 4'd2, 8'h02));
    for (int i = 0; i < int'(rx_len_v); i++) begin
      exp_q.push_back(ev(K_RD, 4'd3, 8'h00));
      exp_q.push_back(ev(K_RXB, {3'b000, (i == int'(rx_len_v) - 1)}, rx_mem[i]));
    end
  endtask

  task automatic exp_tx(int n);
    for (int i = 0; i < n && i < 126; i++) exp_q.push_back(ev(K_WR, 4'd1, tx_buf[i]));
    if (n > 126) exp_q.push_back(ev(K_OVR, 4'h0, 8'h00));
    exp_q.push_back(ev(K_WR, 4'd0, 8'h02));
  endtask

  task automatic tx_send(logic [7:0] d, logic last);
    int w;
    bus.TxData  = d;
    bus.TxLast  = last;
    bus.TxValid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!bus.TxReady && w < 400) begin
      w++;
      @(negedge clk);
    end
    if (!bus.TxReady) chk("tx ready timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic tx_frame(int n);
    for (int i = 0; i < n; i++) tx_send(tx_buf[i], (i == n - 1));
    bus.TxValid = 1'b0;
    bus.TxLast  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic load_rx(int len, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2);
    rx_len_v  = 8'(len);
    rx_mem[0] = b0;
    rx_mem[1] = b1;
    rx_mem[2] = b2;
  endtask

  initial begin
    int n;
    int rd0;
    bus.TxValid = 1'b0;
    bus.TxData  = 8'h00;
    bus.TxLast  = 1'b0;
    bus.RxReady = 1'b1;
    bus.Tx_Done = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", out_vec(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // RX frame AA BB CC with first-byte latency
    load_rx(3, 8'hAA, 8'hBB, 8'hCC);
    exp_rx();
    rx_loaded = rx_loaded + 1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!bus.RxValid && n < 50);
    chk("rx first-byte latency", n, 5);
    drain();

    // TX frame 11 22 33, HDLC busy at first
    bus.Tx_Done = 1'b0;
    tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; tx_buf[2] = 8'h33;
    exp_tx(3);
    fork
      tx_frame(3);
      begin
        repeat (6) @(negedge clk);
        chk("txready while tx_done low", int'(bus.TxReady), 0);
        @(posedge clk);
        #1;
        bus.Tx_Done = 1'b1;
      end
    join
    drain();

    // Simultaneous requests twice: RX then TX each time
    for (int r = 0; r < 2; r++) begin
      load_rx(2, 8'h5A, 8'hA5, 8'h00);
      tx_buf[0] = 8'h01; tx_buf[1] = 8'h02; tx_buf[2] = 8'h03;
      exp_rx();
      exp_tx(3);
      fork
        tx_frame(3);
        rx_loaded = rx_loaded + 1;
      join
      drain();
    end

    // RX alone, then both pending: TX wins the round-robin
    load_rx(1, 8'h77, 8'h00, 8'h00);
    exp_rx();
    rx_loaded = rx_loaded + 1;
    drain();
    load_rx(1, 8'h99, 8'h00, 8'h00);
    tx_buf[0] = 8'h42;
    exp_tx(1);
    exp_rx();
    fork
      tx_frame(1);
      rx_loaded = rx_loaded + 1;
    join
    drain();

    // Zero-length RX frame: drop write only
    load_rx(0, 8'h00, 8'h00, 8'h00);
    exp_rx();
    rx_loaded = rx_loaded + 1;
    drain();

    // Back-pressure: RxReady low for 10 cycles on the first byte
    bus.RxReady = 1'b0;
    load_rx(3, 8'h01, 8'h02, 8'h03);
    exp_rx();
    rx_loaded = rx_loaded + 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.RxValid && n < 50);
    rd0 = rd_seen;
    repeat (10) @(negedge clk);
    chk("reads during stall", rd_seen - rd0, 0);
    chk("stalled rx byte held", int'({bus.RxValid, bus.RxData}), 32'h101);
    @(posedge clk);
    #1;
    bus.RxReady = 1'b1;
    drain();

    // 130-byte TX frame: 126 writes, overrun pulse, 4 discarded, one start
    for (int i = 0; i < 130; i++) tx_buf[i] = 8'(i + 16);
    exp_tx(130);
    tx_frame(130);
    drain();

    // Reset in the middle of a TX frame
    tx_buf[0] = 8'h51; tx_buf[1] = 8'h52;
    exp_q.push_back(ev(K_WR, 4'd1, 8'h51));
    exp_q.push_back(ev(K_WR, 4'd1, 8'h52));
    tx_send(8'h51, 1'b0);
    tx_send(8'h52, 1'b0);
    rst = 1'b1;
    bus.TxValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("outputs after mid-tx reset", out_vec(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drain();

    // After reset both pending: RX first
    load_rx(2, 8'h3C, 8'hC3, 8'h00);
    tx_buf[0] = 8'h61; tx_buf[1] = 8'h62;
    exp_rx();
    exp_tx(2);
    fork
      tx_frame(2);
      rx_loaded = rx_loaded + 1;
    join
    drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
